// File: rtl/i2s_pkg.sv
// Shared constants and state encoding for the I2S transmit controller.
package i2s_pkg;

    // Default channel word width; must match the downstream serializer.
    localparam int I2S_DATA_WIDTH = 32;

    // Default number of clk cycles per sck period (even, >= 4).
    localparam int I2S_SCK_DIV = 8;

    // Default width of the saturating underrun counter.
    localparam int I2S_UNDERRUN_CNT_WIDTH = 16;

    // Controller state: IDLE holds the bit clock parked, RUN streams frames.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit clock and word select generator.
//
// Holds the divider counter (div_cnt), the bit-within-word counter (bit_cnt),
// and the registered sck/ws outputs. While run_i is low every register is
// parked at its idle value (sck = 0, ws = 1, counters 0). start_i marks the
// edge that enters RUN: counters restart and ws drops to select the left word.
//
// half_o and frame_o are decoded from the current registers and are high in
// the last clk cycle of the left and right word respectively, i.e. they flag
// the edge on which ws is about to toggle.
module i2s_sck_gen
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH,
    parameter int SCK_DIV    = I2S_SCK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic start_i,
    output logic sck_o,
    output logic ws_o,
    output logic half_o,
    output logic frame_o
);

    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             sck_q, sck_d;
    logic             ws_q, ws_d;

    logic div_wrap;
    logic word_end;

    assign div_wrap = (div_cnt_q == DIV_LAST);
    assign word_end = div_wrap && (bit_cnt_q == BIT_LAST);

    // End-of-word strobes; ws tells which half of the frame is ending.
    assign half_o  = word_end && !ws_q;
    assign frame_o = word_end && ws_q;

    assign sck_o = sck_q;
    assign ws_o  = ws_q;

    // Next-state for the divider, bit counter, sck and ws.
    always_comb begin
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sck_d     = sck_q;
        ws_d      = ws_q;

        if (!run_i) begin
            // Parked: bit clock low, word select on the right channel.
            div_cnt_d = '0;
            bit_cnt_d = '0;
            sck_d     = 1'b0;
            ws_d      = 1'b1;
        end else if (start_i) begin
            // Entry edge behaves like a frame boundary: left word begins.
            div_cnt_d = '0;
            bit_cnt_d = '0;
            sck_d     = 1'b0;
            ws_d      = 1'b0;
        end else begin
            if (div_wrap) begin
                div_cnt_d = '0;
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    ws_d      = ~ws_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
            // sck is low for the first half of each divider period, so every
            // ws toggle (div_cnt back to 0) coincides with sck going low.
            sck_d = (div_cnt_d >= DIV_HALF);
        end
    end

    // Counter and clock output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sck_q     <= 1'b0;
            ws_q      <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sck_q     <= sck_d;
            ws_q      <= ws_d;
        end
    end

endmodule

// File: rtl/i2s_tx_controller.sv
// I2S transmit sequencing controller.
//
// Upstream handshake: a pair (in_left, in_right) is transferred on every
// clk edge where in_valid && in_ready. in_ready is the registered inverse of
// the one-entry buffer flag, so it never depends on in_valid in the same
// cycle; in_valid may be asserted at any time and the pair is held by the
// source until accepted.
//
// At each frame boundary the buffered pair (or zeros, on underrun) is moved
// into data_left/data_right, which then stay stable for the whole frame.
// A pair accepted on the boundary edge itself is not bypassed; it waits in
// the buffer for the following frame.
module i2s_tx_controller
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH         = I2S_DATA_WIDTH,
    parameter int SCK_DIV            = I2S_SCK_DIV,
    parameter int UNDERRUN_CNT_WIDTH = I2S_UNDERRUN_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_left,
    input  logic [DATA_WIDTH-1:0]         in_right,
    output logic                          sck,
    output logic                          ws,
    output logic [DATA_WIDTH-1:0]         data_left,
    output logic [DATA_WIDTH-1:0]         data_right,
    output logic                          frame_start,
    output logic                          underrun,
    output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count,
    output logic                          busy
);

    // FSM
    state_e state_q, state_d;
    logic   gen_run;
    logic   gen_start;
    logic   frame_evt;

    // Timing strobes from the bit clock generator
    logic frame_bnd;
    logic half_bnd_unused;

    // Prefetch buffer
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] buf_left_q, buf_left_d;
    logic [DATA_WIDTH-1:0] buf_right_q, buf_right_d;
    logic                  accept;

    // Output registers
    logic [DATA_WIDTH-1:0]         data_left_q, data_left_d;
    logic [DATA_WIDTH-1:0]         data_right_q, data_right_d;
    logic                          frame_start_q, frame_start_d;
    logic                          underrun_q, underrun_d;
    logic [UNDERRUN_CNT_WIDTH-1:0] ucnt_q, ucnt_d;

    i2s_sck_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .SCK_DIV    (SCK_DIV)
    ) u_sck_gen (
        .clk     (clk),
        .rst     (rst),
        .run_i   (gen_run),
        .start_i (gen_start),
        .sck_o   (sck),
        .ws_o    (ws),
        .half_o  (half_bnd_unused),
        .frame_o (frame_bnd)
    );

    // FSM next state: enter RUN on enable, leave only at a frame boundary.
    always_comb begin
        state_d   = state_q;
        gen_start = 1'b0;
        frame_evt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_RUN;
                    gen_start = 1'b1;
                    frame_evt = 1'b1;
                end
            end
            ST_RUN: begin
                // Enable is only looked at here, so a frame in flight always
                // finishes its right word before the controller parks.
                if (frame_bnd) begin
                    if (enable) begin
                        frame_evt = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        gen_run = (state_d == ST_RUN);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign accept = in_valid && !buf_full_q;

    // Buffer, frame output and underrun next-state.
    always_comb begin
        buf_full_d    = buf_full_q;
        buf_left_d    = buf_left_q;
        buf_right_d   = buf_right_q;
        data_left_d   = data_left_q;
        data_right_d  = data_right_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        ucnt_d        = ucnt_q;

        if (frame_evt) begin
            frame_start_d = 1'b1;
            if (buf_full_q) begin
                data_left_d  = buf_left_q;
                data_right_d = buf_right_q;
                buf_full_d   = 1'b0;
            end else begin
                data_left_d  = '0;
                data_right_d = '0;
                underrun_d   = 1'b1;
                if (ucnt_q != '1) begin
                    ucnt_d = ucnt_q + 1'b1;
                end
            end
        end

        // accept implies the buffer was empty, so it never collides with a
        // load out of the buffer above.
        if (accept) begin
            buf_full_d  = 1'b1;
            buf_left_d  = in_left;
            buf_right_d = in_right;
        end
    end

    // Buffer and output registers; reset discards any buffered pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full_q    <= 1'b0;
            buf_left_q    <= '0;
            buf_right_q   <= '0;
            data_left_q   <= '0;
            data_right_q  <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            ucnt_q        <= '0;
        end else begin
            buf_full_q    <= buf_full_d;
            buf_left_q    <= buf_left_d;
            buf_right_q   <= buf_right_d;
            data_left_q   <= data_left_d;
            data_right_q  <= data_right_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            ucnt_q        <= ucnt_d;
        end
    end

    assign in_ready       = !buf_full_q;
    assign data_left      = data_left_q;
    assign data_right     = data_right_q;
    assign frame_start    = frame_start_q;
    assign underrun       = underrun_q;
    assign underrun_count = ucnt_q;
    assign busy           = (state_q == ST_RUN);

endmodule

// File: tb/tb_i2s_tx_controller.sv
// Testbench for i2s_tx_controller (DATA_WIDTH 32, SCK_DIV 8, 2-bit underrun
// counter so saturation is reachable in a few frames).
module tb_i2s_tx_controller;

    localparam int DW      = 32;
    localparam int DIV     = 8;
    localparam int UW      = 2;
    localparam int HALF    = DW * DIV;
    localparam int FRAME   = 2 * HALF;
    localparam int CNT_MAX = (1 << UW) - 1;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_left;
    logic [DW-1:0] in_right;
    logic          sck;
    logic          ws;
    logic [DW-1:0] data_left;
    logic [DW-1:0] data_right;
    logic          frame_start;
    logic          underrun;
    logic [UW-1:0] underrun_count;
    logic          busy;

    int checks = 0;
    int errors = 0;
    bit mon_on = 0;
    int cur_off = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    i2s_tx_controller #(
        .DATA_WIDTH         (DW),
        .SCK_DIV            (DIV),
        .UNDERRUN_CNT_WIDTH (UW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_left        (in_left),
        .in_right       (in_right),
        .sck            (sck),
        .ws             (ws),
        .data_left      (data_left),
        .data_right     (data_right),
        .frame_start    (frame_start),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .busy           (busy)
    );

    // ---------------- comparison ----------------
    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time-based view: m_t is the number of clk edges since the current run
    // started (entry edge = 0); sck and ws follow from plain arithmetic on it.
    bit          m_run   = 0;
    int          m_t     = 0;
    bit          m_bfull = 0;
    logic [DW-1:0] m_bl  = '0;
    logic [DW-1:0] m_br  = '0;
    logic [DW-1:0] m_dl  = '0;
    logic [DW-1:0] m_dr  = '0;
    bit          m_fs    = 0;
    bit          m_ur    = 0;
    int          m_cnt   = 0;
    bit          m_acc;
    bit          m_bnd;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_run = 0; m_t = 0; m_bfull = 0; m_bl = '0; m_br = '0;
            m_dl = '0; m_dr = '0; m_fs = 0; m_ur = 0; m_cnt = 0;
        end else begin
            m_acc = in_valid && !m_bfull;
            m_bnd = m_run ? (((m_t + 1) % FRAME) == 0) : enable;
            m_fs  = 0;
            m_ur  = 0;
            if (m_bnd && !enable) begin
                m_run = 0;
                m_t   = 0;
            end else if (m_bnd) begin
                m_run = 1;
                m_t   = 0;
                m_fs  = 1;
                if (m_bfull) begin
                    m_dl = m_bl; m_dr = m_br; m_bfull = 0;
                end else begin
                    m_dl = '0; m_dr = '0; m_ur = 1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
            end else if (m_run) begin
                m_t++;
            end
            if (m_acc) begin
                m_bfull = 1; m_bl = in_left; m_br = in_right;
            end
        end
    end

    // Every cycle, compare all outputs against the model on the falling edge.
    initial forever begin
        logic e_sck;
        logic e_ws;
        @(negedge clk);
        if (mon_on) begin
            e_sck = m_run && ((m_t % DIV) >= (DIV / 2));
            e_ws  = m_run ? (((m_t / HALF) % 2) == 1) : 1'b1;
            chk("model_ctl",
                96'({sck, ws, frame_start, underrun, busy, in_ready, underrun_count}),
                96'({e_sck, e_ws, m_fs, m_ur, m_run, !m_bfull, m_cnt[UW-1:0]}));
            chk("model_data", 96'({data_left, data_right}), 96'({m_dl, m_dr}));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Raise enable (called right after a falling edge); the next rising edge
    // is the RUN entry edge, offset 0.
    task automatic start_run();
        enable = 1'b1;
        @(posedge clk);
        cur_off = -1;
    endtask

    // Advance to the falling edge that follows entry-relative edge k.
    task automatic goto_off(input int k);
        repeat (k - cur_off) @(negedge clk);
        cur_off = k;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk(name, 96'(busy), 96'(0));
    endtask

    // ---------------- checkpoint table ----------------
    typedef struct {
        int            off;
        logic          ws;
        logic          sck;
        logic          fs;
        logic          ur;
        logic [DW-1:0] dl;
        logic [DW-1:0] dr;
    } vec_t;

    vec_t vecs[8];
    int   exp_cnt[5];

    initial begin
        vecs[0] = '{0,   1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[1] = '{3,   1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[2] = '{4,   1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[3] = '{255, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[4] = '{256, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[5] = '{260, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[6] = '{511, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[7] = '{512, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0};
        exp_cnt = '{1, 2, 3, 3, 3};

        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_sck",   96'(sck), 96'(0));
        chk("rst_ws",    96'(ws), 96'(1));
        chk("rst_data",  96'({data_left, data_right}), 96'(0));
        chk("rst_pulse", 96'({frame_start, underrun}), 96'(0));
        chk("rst_cnt",   96'(underrun_count), 96'(0));
        chk("rst_ready", 96'(in_ready), 96'(1));
        chk("rst_busy",  96'(busy), 96'(0));
        rst = 1'b0;
        mon_on = 1'b1;

        // Prefill in IDLE, then enable
        @(negedge clk);
        in_valid = 1'b1; in_left = 32'hA5A5A5A5; in_right = 32'h5A5A5A5A;
        @(negedge clk);
        in_valid = 1'b0;
        chk("prefill_ready", 96'(in_ready), 96'(0));
        chk("prefill_idle",  96'({busy, sck, ws}), 96'(3'b001));
        start_run();
        for (int i = 0; i < 8; i++) begin
            goto_off(vecs[i].off);
            chk($sformatf("vec%0d_ws", i),  96'(ws), 96'(vecs[i].ws));
            chk($sformatf("vec%0d_sck", i), 96'(sck), 96'(vecs[i].sck));
            chk($sformatf("vec%0d_fs", i),  96'(frame_start), 96'(vecs[i].fs));
            chk($sformatf("vec%0d_ur", i),  96'(underrun), 96'(vecs[i].ur));
            chk($sformatf("vec%0d_dl", i),  96'(data_left), 96'(vecs[i].dl));
            chk($sformatf("vec%0d_dr", i),  96'(data_right), 96'(vecs[i].dr));
        end
        enable = 1'b0;
        wait_idle("stop1_idle");

        // Enable with the buffer empty, late pair used next frame
        do_reset();
        start_run();
        goto_off(0);
        chk("empty_ur",   96'({frame_start, underrun}), 96'(2'b11));
        chk("empty_cnt",  96'(underrun_count), 96'(1));
        chk("empty_data", 96'({data_left, data_right}), 96'(0));
        goto_off(1);
        chk("empty_ur_once", 96'(underrun), 96'(0));
        goto_off(10);
        in_valid = 1'b1; in_left = 32'hC0FFEE01; in_right = 32'hC0FFEE02;
        goto_off(11);
        in_valid = 1'b0;
        chk("late_ready", 96'(in_ready), 96'(0));
        goto_off(511);
        chk("late_hold", 96'(data_left), 96'(0));
        goto_off(512);
        chk("late_data", 96'({data_left, data_right}), 96'({32'hC0FFEE01, 32'hC0FFEE02}));
        chk("late_fs",   96'({frame_start, underrun, underrun_count}), 96'(4'b1001));

        // Continuous streaming of four pairs
        do_reset();
        in_valid = 1'b1; in_left = 32'h1; in_right = 32'h11;
        @(negedge clk);
        in_valid = 1'b0;
        start_run();
        for (int f = 0; f < 4; f++) begin
            goto_off(f * FRAME);
            chk($sformatf("stream%0d_dl", f), 96'(data_left), 96'(f + 1));
            chk($sformatf("stream%0d_dr", f), 96'(data_right), 96'(32'h11 + f));
            chk($sformatf("stream%0d_fs", f), 96'({frame_start, underrun}), 96'(2'b10));
            if (f < 3) begin
                in_valid = 1'b1; in_left = DW'(f + 2); in_right = DW'(32'h12 + f);
                goto_off(f * FRAME + 1);
                in_valid = 1'b0;
            end
        end
        chk("stream_cnt", 96'(underrun_count), 96'(0));

        // Drop enable 100 cycles into the last frame; pair offered meanwhile is kept
        goto_off(3 * FRAME + 100);
        enable = 1'b0;
        goto_off(3 * FRAME + 150);
        in_valid = 1'b1; in_left = 32'h77; in_right = 32'h88;
        goto_off(3 * FRAME + 151);
        in_valid = 1'b0;
        goto_off(3 * FRAME + 255);
        chk("drop_ws255", 96'(ws), 96'(0));
        goto_off(3 * FRAME + 256);
        chk("drop_ws256", 96'(ws), 96'(1));
        goto_off(3 * FRAME + 511);
        chk("drop_busy511", 96'(busy), 96'(1));
        goto_off(3 * FRAME + 512);
        chk("drop_idle", 96'({busy, sck, ws, frame_start, underrun}), 96'(5'b00100));
        chk("drop_kept", 96'({in_ready, data_left}), 96'({1'b0, 32'h4}));

        // Asynchronous reset 300 cycles into a frame
        start_run();
        goto_off(0);
        chk("rerun_dl", 96'({data_left, data_right}), 96'({32'h77, 32'h88}));
        goto_off(50);
        in_valid = 1'b1; in_left = 32'h99; in_right = 32'hAA;
        goto_off(51);
        in_valid = 1'b0;
        goto_off(300);
        chk("pre_rst", 96'({sck, busy, in_ready}), 96'(3'b110));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async",
            96'({sck, ws, frame_start, underrun, busy, in_ready, underrun_count, data_left, data_right}),
            96'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0}));
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Underrun counter saturation
        do_reset();
        start_run();
        for (int k = 0; k < 5; k++) begin
            goto_off(k * FRAME);
            chk($sformatf("sat%0d_ur", k),  96'(underrun), 96'(1));
            chk($sformatf("sat%0d_cnt", k), 96'(underrun_count), 96'(exp_cnt[k]));
        end
        enable = 1'b0;
        wait_idle("sat_idle");

        // Randomized traffic against the model
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) == 0);
            in_left  = $urandom;
            in_right = $urandom;
            if ($urandom_range(0, 299) == 0) enable = !enable;
        end
        in_valid = 1'b0;
        enable   = 1'b0;
        wait_idle("rand_idle");

        @(negedge clk);
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx_controller.md
# i2s_tx_controller

Sequencing controller for the I2S transmit path. Generates the bit clock (`sck`) and word select (`ws`) from the system clock. Accepts stereo sample pairs from an upstream source over a valid/ready handshake through a one-entry prefetch buffer. Presents each pair on `data_left`/`data_right`, held stable for a full frame, to the downstream I2S serializer, and substitutes zeros on underrun.

## Interface
- `DATA_WIDTH`, 32: bits per channel word; must match the serializer.
- `SCK_DIV`, 8: `clk` cycles per `sck` period; even, ≥4.
- `UNDERRUN_CNT_WIDTH`, 16: width of the saturating underrun counter.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run request; level-sensitive.
- `in_valid`  in  1  upstream pair valid.
- `in_ready`  out  1  buffer can accept; equals `!buf_full`.
- `in_left`  in  DATA_WIDTH  upstream left sample.
- `in_right`  in  DATA_WIDTH  upstream right sample.
- `sck`  out  1  I2S bit clock, registered.
- `ws`  out  1  word select (0 = left, 1 = right), registered.
- `data_left`  out  DATA_WIDTH  current-frame left word.
- `data_right`  out  DATA_WIDTH  current-frame right word.
- `frame_start`  out  1  one-cycle pulse at each frame boundary.
- `underrun`  out  1  one-cycle pulse when a frame boundary finds the buffer empty.
- `underrun_count`  out  UNDERRUN_CNT_WIDTH  saturating count of underruns.
- `busy`  out  1  high while in RUN.

## Operation
- Two states: IDLE and RUN.
- Reset values:
  - state = IDLE
  - `sck` = 0, `ws` = 1
  - `data_left` = `data_right` = 0
  - `frame_start` = `underrun` = 0
  - `underrun_count` = 0
  - buffer empty, so `in_ready` = 1
  - `busy` = 0
  - internal `div_cnt` = `bit_cnt` = 0
- Buffer accept: capture on `in_valid && in_ready`. This is independent of state, so prefill in IDLE is allowed. The buffer holds one pair; `in_ready` drops the cycle after capture.
- IDLE:
  - `sck` is held 0 and `ws` is held 1; counters are held at 0.
  - When `enable` = 1, the next edge goes to RUN and is treated as a frame boundary.
- RUN:
  - `div_cnt` counts 0..SCK_DIV-1 and wraps.
  - `sck` = 0 while `div_cnt` < SCK_DIV/2; `sck` = 1 otherwise.
  - `bit_cnt` increments on each `div_cnt` wrap and wraps after DATA_WIDTH-1.
- Half boundary: `div_cnt` = SCK_DIV-1, `bit_cnt` = DATA_WIDTH-1, `ws` = 0. On this edge `ws` goes to 1. Outputs are untouched.
- Frame boundary: `div_cnt` = SCK_DIV-1, `bit_cnt` = DATA_WIDTH-1, `ws` = 1, or the IDLE→RUN entry edge.
  - If `enable` = 0 (not applicable on the entry edge): go to IDLE. `ws` stays 1. No load, no pulses.
  - Else, `ws` goes to 0, counters go to 0, and `frame_start` = 1.
  - If the buffer is full: `data_left`/`data_right` are loaded from the buffer and the buffer is emptied.
  - If the buffer is empty: `data_left`/`data_right` are set to 0, `underrun` = 1, and `underrun_count` increments, saturating at all-ones.
- Simultaneous accept and frame boundary with the buffer empty: this counts as an underrun. The new pair enters the buffer and is used at the next frame. There is no bypass.
- Simultaneous accept and frame boundary with the buffer full: impossible, because `in_ready` = 0.
- Deasserting `enable` mid-frame does not abort the frame. The controller completes the right word, then goes to IDLE. Buffer contents are retained.
- `rst` mid-frame forces all reset values immediately, asynchronously. Buffer contents are discarded.

## Timing
- All outputs are registered. `in_ready` is the registered buffer flag, with no combinational path from `in_valid`.
- Frame period is 2·DATA_WIDTH·SCK_DIV `clk` cycles (512 at defaults). `ws` toggles every DATA_WIDTH·SCK_DIV cycles, always coincident with `sck` going low.
- `data_left`/`data_right` change only on frame-boundary edges, in the same cycle that `ws` goes to 0 and `frame_start` pulses. They are stable for the whole frame, which gives the serializer ≥ DATA_WIDTH·SCK_DIV cycles of setup before it latches the right word.
- First `sck` rising edge occurs SCK_DIV/2 cycles after RUN entry.
- Accept-to-output latency is 1 cycle minimum (buffer), up to one frame period maximum.

## Structure
- Shared package `i2s_pkg` holds the default constants DATA_WIDTH = 32 and SCK_DIV = 8, plus the state encoding (IDLE, RUN).
- One natural sub-module, `i2s_sck_gen`, contains `div_cnt`, `bit_cnt`, `sck` and `ws`. It provides half- and frame-boundary strobes, plus a run/hold input.
- The top level contains the FSM, prefetch buffer, output registers and underrun counter.

## Test plan
- Prefill in IDLE: offer (L=0xA5A5A5A5, R=0x5A5A5A5A), then raise `enable`.
  - Expected: `frame_start` and `ws` = 0 on the entry edge, data outputs = those values, `underrun` = 0.
  - `ws` = 1 exactly 256 cycles later, 0 at 512.
- Enable with the buffer empty.
  - Expected: `underrun` pulses once, `underrun_count` = 1, data outputs = 0.
  - A pair presented 10 cycles later appears at cycle 512.
- Continuous streaming of 4 pairs, 0x1..0x4 left and 0x11..0x14 right, each offered promptly after `in_ready`.
  - Expected: 4 consecutive frames with matching values and no underrun.
- Drop `enable` at cycle 100 of a frame.
  - Expected: `ws` still toggles at 256. The controller enters IDLE at the 512 boundary with `sck` = 0, `ws` = 1, `busy` = 0, and no `frame_start`.
- Assert `rst` at cycle 300 mid-frame.
  - Expected: all outputs are at reset values in the same cycle, asynchronously, and `in_ready` = 1.
- Parameterise UNDERRUN_CNT_WIDTH = 2 and force 5 underruns.
  - Expected: the count reads 1, 2, 3, 3, 3, and `underrun` pulses all 5 times.
